// File: rtl/shift_exec_stage_pkg.sv
// rtl/shift_exec_stage_pkg.sv - shared constants, opcode enum and buffered result type
package shift_exec_stage_pkg;

    // WIDTH is the datapath width. SHAMT_W must stay log2(WIDTH) so that
    // every shift amount 0..WIDTH-1 can be expressed.
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;
    localparam int TAG_W   = 3;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // One buffered result: the value plus its flags and destination tag.
    // The head register and the skid register both use this type.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

endpackage

// File: rtl/shift_exec_stage_if.sv
// rtl/shift_exec_stage_if.sv - operand-fetch and writeback handshake bundle
interface shift_exec_stage_if;
    import shift_exec_stage_pkg::*;

    // Operand-fetch side
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;

    // Writeback side
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;
    logic               out_carry;
    logic               out_zero;
    logic               out_neg;
    logic [TAG_W-1:0]   out_tag;

    // The environment: issues operations and consumes results
    modport master (
        output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_neg, out_tag
    );

    // The execute stage itself
    modport slave (
        input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_neg, out_tag
    );
endinterface

// File: rtl/shift_exec_stage_core.sv
// rtl/shift_exec_stage_core.sv - combinational log-stage shifter with carry and flags
module shift_core
    import shift_exec_stage_pkg::*;
(
    input  op_e                op,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               neg
);

    // Left and right shifters carry one guard bit each. The guard bit ends
    // up holding the last bit shifted out, and stays 0 when shamt is 0.
    logic [WIDTH:0]   left_ext;
    logic [WIDTH:0]   right_ext;
    logic [WIDTH-1:0] rot;

    // Binary-weighted stages for all three networks, then select by opcode
    always_comb begin
        left_ext  = {1'b0, data};
        right_ext = {data, 1'b0};
        rot       = data;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (shamt[k]) begin
                left_ext = left_ext << (1 << k);
                if (op == OP_SRA) begin
                    right_ext = $unsigned($signed(right_ext) >>> (1 << k));
                end else begin
                    right_ext = right_ext >> (1 << k);
                end
                rot = (rot >> (1 << k)) | (rot << (WIDTH - (1 << k)));
            end
        end

        result = data;
        carry  = 1'b0;
        case (op)
            OP_SLL: begin
                result = left_ext[WIDTH-1:0];
                carry  = left_ext[WIDTH];
            end
            OP_SRL, OP_SRA: begin
                result = right_ext[WIDTH:1];
                carry  = right_ext[0];
            end
            default: begin
                result = rot;
                carry  = (shamt != '0) & rot[WIDTH-1];
            end
        endcase

        zero = (result == '0);
        neg  = result[WIDTH-1];
    end

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - registered shift execute stage with 2-entry output buffer
module shift_exec_stage
    import shift_exec_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    shift_exec_stage_if.slave  bus
);

    state_e state, state_next;
    res_t   head, skid;
    res_t   core_res;

    logic   accept;
    logic   xfer;
    logic   load_head_core;
    logic   load_head_skid;
    logic   load_skid;

    shift_core u_core (
        .op     (op_e'(bus.in_op)),
        .data   (bus.in_data),
        .shamt  (bus.in_shamt),
        .result (core_res.result),
        .carry  (core_res.carry),
        .zero   (core_res.zero),
        .neg    (core_res.neg)
    );

    assign core_res.tag = bus.in_tag;

    // in_ready depends on state and reset only, never on out_ready
    assign bus.in_ready  = (state != ST_TWO) & ~reset;
    assign bus.out_valid = (state != ST_EMPTY);

    assign accept = bus.in_valid & bus.in_ready;
    assign xfer   = bus.out_valid & bus.out_ready;

    assign bus.out_result = head.result;
    assign bus.out_carry  = head.carry;
    assign bus.out_zero   = head.zero;
    assign bus.out_neg    = head.neg;
    assign bus.out_tag    = head.tag;

    // Buffer control: next state and which register loads from where
    always_comb begin
        state_next     = state;
        load_head_core = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next     = ST_ONE;
                    load_head_core = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    load_head_core = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_next     = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // State, head and skid registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_next;
            if (load_head_core) begin
                head <= core_res;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= core_res;
            end
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - directed self-checking bench for shift_exec_stage
module tb_shift_exec_stage;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    shift_exec_stage_if bus ();

    shift_exec_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] data,
                         input logic [3:0] shamt, input logic [2:0] tag);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        bus.in_shamt = shamt;
        bus.in_tag   = tag;
    endtask

    // Issue one op into an empty stage with out_ready=1 and check the result
    task automatic single(input string name, input logic [1:0] op, input logic [15:0] data,
                          input logic [3:0] shamt, input logic [15:0] exp_res,
                          input logic exp_carry);
        bus.out_ready = 1'b1;
        drive(op, data, shamt, 3'd4);
        step();
        bus.in_valid = 1'b0;
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_result"}, 32'(bus.out_result), 32'(exp_res));
        check({name, "_carry"}, 32'(bus.out_carry), 32'(exp_carry));
        check({name, "_zero"}, 32'(bus.out_zero), 32'(exp_res == 16'h0000));
        check({name, "_neg"}, 32'(bus.out_neg), 32'(exp_res[15]));
        check({name, "_tag"}, 32'(bus.out_tag), 32'd4);
        step();
        check({name, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_data   = 16'h0000;
        bus.in_shamt  = 4'd0;
        bus.in_tag    = 3'd0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_carry", 32'(bus.out_carry), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        check("rst_out_neg", 32'(bus.out_neg), 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Shift core vectors
        single("sra_8001_1",  2'b10, 16'h8001, 4'd1,  16'hC000, 1'b1);
        single("sll_8001_15", 2'b00, 16'h8001, 4'd15, 16'h8000, 1'b0);
        single("ror_0003_1",  2'b11, 16'h0003, 4'd1,  16'h8001, 1'b1);
        single("sll_1234_0",  2'b00, 16'h1234, 4'd0,  16'h1234, 1'b0);
        single("srl_1234_0",  2'b01, 16'h1234, 4'd0,  16'h1234, 1'b0);
        single("sra_1234_0",  2'b10, 16'h1234, 4'd0,  16'h1234, 1'b0);
        single("ror_1234_0",  2'b11, 16'h1234, 4'd0,  16'h1234, 1'b0);
        single("srl_0001_1",  2'b01, 16'h0001, 4'd1,  16'h0000, 1'b1);
        single("sra_8000_15", 2'b10, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        single("sll_4000_2",  2'b00, 16'h4000, 4'd2,  16'h0000, 1'b1);
        single("ror_1234_4",  2'b11, 16'h1234, 4'd4,  16'h4123, 1'b0);
        single("ror_000f_4",  2'b11, 16'h000F, 4'd4,  16'hF000, 1'b1);
        single("srl_ffff_15", 2'b01, 16'hFFFF, 4'd15, 16'h0001, 1'b1);
        single("sra_7ff0_3",  2'b10, 16'h7FF0, 4'd3,  16'h0FFE, 1'b0);

        // Back-pressure: tags 1,2,3 with writeback stalled; results are tag<<1
        bus.out_ready = 1'b0;
        drive(2'b00, 16'h0001, 4'd1, 3'd1);
        check("bp_ready_empty", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_one_ready", 32'(bus.in_ready), 32'd1);
        check("bp_one_tag", 32'(bus.out_tag), 32'd1);
        drive(2'b00, 16'h0002, 4'd1, 3'd2);
        step();
        check("bp_two_ready", 32'(bus.in_ready), 32'd0);
        check("bp_two_tag", 32'(bus.out_tag), 32'd1);
        drive(2'b00, 16'h0003, 4'd1, 3'd3);
        step();
        check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
        check("bp_stall_tag", 32'(bus.out_tag), 32'd1);
        check("bp_stall_result", 32'(bus.out_result), 32'h0002);
        check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_drain1_tag", 32'(bus.out_tag), 32'd2);
        check("bp_drain1_result", 32'(bus.out_result), 32'h0004);
        check("bp_drain1_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_drain2_tag", 32'(bus.out_tag), 32'd3);
        check("bp_drain2_result", 32'(bus.out_result), 32'h0006);
        check("bp_drain2_valid", 32'(bus.out_valid), 32'd1);
        step();
        check("bp_empty_valid", 32'(bus.out_valid), 32'd0);

        // Full throughput: SRL by 4 of i<<8 gives i<<4
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, 16'(i << 8), 4'd4, 3'(i));
            check($sformatf("tp_ready_%0d", i), 32'(bus.in_ready), 32'd1);
            step();
            check($sformatf("tp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("tp_tag_%0d", i), 32'(bus.out_tag), 32'(i));
            check($sformatf("tp_result_%0d", i), 32'(bus.out_result), 32'(i << 4));
        end
        bus.in_valid = 1'b0;
        step();
        check("tp_empty_valid", 32'(bus.out_valid), 32'd0);

        // Reset while two results are buffered
        bus.out_ready = 1'b0;
        drive(2'b11, 16'h00F0, 4'd4, 3'd5);
        step();
        drive(2'b11, 16'h0F00, 4'd4, 3'd6);
        step();
        bus.in_valid = 1'b0;
        check("rt_two_ready", 32'(bus.in_ready), 32'd0);
        check("rt_two_tag", 32'(bus.out_tag), 32'd5);
        reset = 1'b1;
        #1;
        check("rt_rst_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("rt_rst_valid", 32'(bus.out_valid), 32'd0);
        check("rt_rst_result", 32'(bus.out_result), 32'd0);
        check("rt_rst_tag", 32'(bus.out_tag), 32'd0);
        reset = 1'b0;
        #1;
        check("rt_post_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("rt_no_replay", 32'(bus.out_valid), 32'd0);
        drive(2'b00, 16'h0003, 4'd2, 3'd2);
        step();
        bus.in_valid = 1'b0;
        check("rt_new_tag", 32'(bus.out_tag), 32'd2);
        check("rt_new_result", 32'(bus.out_result), 32'h000C);
        step();
        check("rt_new_drained", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
